// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - data-hazard scoreboard: youngest-producer forwarding and load-use stall
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid_i,
  input  logic [AW-1:0]                id_rs1_i,
  input  logic [AW-1:0]                id_rs2_i,
  input  logic                         id_rs1_use_i,
  input  logic                         id_rs2_use_i,
  input  logic [AW-1:0]                id_rd_i,
  input  logic                         id_rd_we_i,
  input  logic                         id_is_load_i,
  input  logic [XLEN-1:0]              rf_rs1_data_i,
  input  logic [XLEN-1:0]              rf_rs2_data_i,
  input  logic [STAGES*XLEN-1:0]       stage_data_i,
  input  logic                         hold_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic [XLEN-1:0]              rs1_data_o,
  output logic [XLEN-1:0]              rs2_data_o,
  output logic [$clog2(STAGES+1)-1:0]  rs1_fwd_o,
  output logic [$clog2(STAGES+1)-1:0]  rs2_fwd_o,
  output logic [STAGES-1:0]            inflight_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  localparam int FW = $clog2(STAGES+1);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] we;
  logic [STAGES-1:0] is_load;
  logic [AW-1:0]     rd [STAGES];
  logic [CNT_W-1:0]  cnt;

  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] match1;
  logic [STAGES-1:0] match2;
  logic              hit1, hit2;
  logic              rdy1, rdy2;
  logic [FW-1:0]     sel1, sel2;
  logic [XLEN-1:0]   fwd_data1, fwd_data2;
  logic              hazard;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ready[k]  = !is_load[k] || (k >= LOAD_STAGE);
      match1[k] = valid[k] && we[k] && (rd[k] == id_rs1_i) && (id_rs1_i != '0)
                  && id_rs1_use_i && id_valid_i;
      match2[k] = valid[k] && we[k] && (rd[k] == id_rs2_i) && (id_rs2_i != '0)
                  && id_rs2_use_i && id_valid_i;
    end
  end

  // Scan oldest to youngest so the lowest matching entry overwrites; an older
  // ready producer must never mask a younger load that is still in flight.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    rdy1      = 1'b1;
    rdy2      = 1'b1;
    sel1      = '0;
    sel2      = '0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (match1[k]) begin
        hit1      = 1'b1;
        rdy1      = ready[k];
        sel1      = FW'(k + 1);
        fwd_data1 = stage_data_i[k*XLEN +: XLEN];
      end
      if (match2[k]) begin
        hit2      = 1'b1;
        rdy2      = ready[k];
        sel2      = FW'(k + 1);
        fwd_data2 = stage_data_i[k*XLEN +: XLEN];
      end
    end
  end

  assign hazard      = (hit1 && !rdy1) || (hit2 && !rdy2);
  assign stall_o     = hazard && !flush_i;
  assign rs1_fwd_o   = sel1;
  assign rs2_fwd_o   = sel2;
  assign rs1_data_o  = hit1 ? fwd_data1 : rf_rs1_data_i;
  assign rs2_data_o  = hit2 ? fwd_data2 : rf_rs2_data_i;
  assign inflight_o  = valid;
  assign stall_cnt_o = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      we      <= '0;
      is_load <= '0;
      cnt     <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd[k] <= '0;
      end
    end else if (!hold_i) begin
      for (int k = STAGES-1; k > 0; k--) begin
        valid[k]   <= valid[k-1];
        we[k]      <= we[k-1];
        is_load[k] <= is_load[k-1];
        rd[k]      <= rd[k-1];
      end
      valid[0]   <= id_valid_i && !stall_o && !flush_i;
      we[0]      <= id_rd_we_i;
      is_load[0] <= id_is_load_i;
      rd[0]      <= id_rd_i;
      if (stall_o && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int STAGES = 3;
  localparam int FW     = $clog2(STAGES+1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   id_valid, id_rs1_use, id_rs2_use, id_rd_we, id_is_load;
  logic [AW-1:0]          id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]        rf1, rf2;
  logic [STAGES*XLEN-1:0] stage_data;
  logic                   hold, flush;

  logic                   stall, stall_s;
  logic [XLEN-1:0]        rs1_data, rs2_data, rs1_data_s, rs2_data_s;
  logic [FW-1:0]          rs1_fwd, rs2_fwd, rs1_fwd_s, rs2_fwd_s;
  logic [STAGES-1:0]      inflight, inflight_s;
  logic [15:0]            cnt;
  logic [3:0]             cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we),
    .id_is_load_i(id_is_load), .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .stage_data_i(stage_data),
    .hold_i(hold), .flush_i(flush), .stall_o(stall), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .rs1_fwd_o(rs1_fwd), .rs2_fwd_o(rs2_fwd), .inflight_o(inflight), .stall_cnt_o(cnt)
  );

  // Narrow-counter twin sharing the same stimulus, used to reach saturation quickly.
  hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_rd_i(id_rd), .id_rd_we_i(id_rd_we),
    .id_is_load_i(id_is_load), .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .stage_data_i(stage_data),
    .hold_i(hold), .flush_i(flush), .stall_o(stall_s), .rs1_data_o(rs1_data_s), .rs2_data_o(rs2_data_s),
    .rs1_fwd_o(rs1_fwd_s), .rs2_fwd_o(rs2_fwd_s), .inflight_o(inflight_s), .stall_cnt_o(cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [AW-1:0] rd, input logic wr, input logic ld);
    id_valid   = 1'b1;
    id_rd      = rd;
    id_rd_we   = wr;
    id_is_load = ld;
    id_rs1     = '0;
    id_rs2     = '0;
    id_rs1_use = 1'b0;
    id_rs2_use = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    rf1   = 32'h1111_1111;
    rf2   = 32'h2222_2222;
    stage_data = '0;
    instr(5'd0, 1'b0, 1'b0);
    id_rs1 = 5'd5;
    id_rs1_use = 1'b1;
    #2;
    check("rst_inflight", 64'(inflight), 64'h0);
    check("rst_cnt", 64'(cnt), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_rs1_fwd", 64'(rs1_fwd), 64'h0);
    check("rst_rs1_data", 64'(rs1_data), 64'h1111_1111);
    #1 rst_n = 1'b1;

    // back-to-back ALU dependency
    instr(5'd5, 1'b1, 1'b0);
    step();
    id_rd_we = 1'b0;
    id_rs1 = 5'd5;
    id_rs1_use = 1'b1;
    stage_data = {32'h0, 32'h0, 32'h0000_1234};
    #1;
    check("alu_fwd", 64'(rs1_fwd), 64'd1);
    check("alu_data", 64'(rs1_data), 64'h0000_1234);
    check("alu_stall", 64'(stall), 64'h0);

    // load-use: lw x6 then a reader of x6
    instr(5'd6, 1'b1, 1'b1);
    step();
    check("lu_inflight", 64'(inflight), 64'b011);
    instr(5'd7, 1'b1, 1'b0);
    id_rs2 = 5'd6;
    id_rs2_use = 1'b1;
    #1;
    check("lu_stall", 64'(stall), 64'h1);
    check("lu_fwd_stalled", 64'(rs2_fwd), 64'd1);
    check("lu_cnt0", 64'(cnt), 64'h0);
    step();
    stage_data = {32'h0, 32'hCAFE_0006, 32'h0};
    #1;
    check("lu_stall_gone", 64'(stall), 64'h0);
    check("lu_fwd2", 64'(rs2_fwd), 64'd2);
    check("lu_data", 64'(rs2_data), 64'hCAFE_0006);
    check("lu_cnt1", 64'(cnt), 64'h1);
    check("lu_bubble", 64'(inflight), 64'b110);
    step();
    id_valid = 1'b0;
    #1;
    check("lu_enter", 64'(inflight), 64'b101);

    // youngest producer wins; unused rs2 does not forward
    step();
    instr(5'd7, 1'b1, 1'b0);
    step();
    instr(5'd0, 1'b0, 1'b0);
    id_rs1 = 5'd7;
    id_rs1_use = 1'b1;
    id_rs2 = 5'd7;
    stage_data = {32'hAAAA_AAAA, 32'h0, 32'h5555_5555};
    #1;
    check("young_inflight", 64'(inflight), 64'b101);
    check("young_fwd", 64'(rs1_fwd), 64'd1);
    check("young_data", 64'(rs1_data), 64'h5555_5555);
    check("unused_fwd", 64'(rs2_fwd), 64'd0);
    check("unused_data", 64'(rs2_data), 64'h2222_2222);

    // writeback entry forwards
    id_valid = 1'b0;
    step();
    step();
    id_valid = 1'b1;
    #1;
    check("wb_fwd", 64'(rs1_fwd), 64'd3);
    check("wb_data", 64'(rs1_data), 64'hAAAA_AAAA);

    // x0 producer never forwards
    instr(5'd0, 1'b1, 1'b0);
    step();
    instr(5'd0, 1'b0, 1'b0);
    id_rs1_use = 1'b1;
    #1;
    check("x0_fwd", 64'(rs1_fwd), 64'd0);
    check("x0_data", 64'(rs1_data), 64'h1111_1111);
    check("x0_stall", 64'(stall), 64'h0);

    // older ready add x8 must not mask younger lw x8; flush beats the hazard
    instr(5'd8, 1'b1, 1'b0);
    step();
    instr(5'd8, 1'b1, 1'b1);
    step();
    instr(5'd0, 1'b0, 1'b0);
    id_rs1 = 5'd8;
    id_rs1_use = 1'b1;
    #1;
    check("older_stall", 64'(stall), 64'h1);
    check("older_fwd", 64'(rs1_fwd), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall), 64'h0);
    step();
    flush = 1'b0;
    #1;
    check("flush_bubble", 64'(inflight), 64'b110);
    check("flush_cnt", 64'(cnt), 64'h1);

    // hold freezes state and counter during a stall
    instr(5'd9, 1'b1, 1'b1);
    step();
    instr(5'd10, 1'b1, 1'b0);
    id_rs2 = 5'd9;
    id_rs2_use = 1'b1;
    hold = 1'b1;
    #1;
    check("hold_stall", 64'(stall), 64'h1);
    step();
    step();
    step();
    check("hold_inflight", 64'(inflight), 64'b101);
    check("hold_cnt", 64'(cnt), 64'h1);
    hold = 1'b0;
    step();
    check("hold_release_cnt", 64'(cnt), 64'h2);
    check("hold_release_fwd", 64'(rs2_fwd), 64'd2);

    // repeated lw x6,(x6): one stall every two cycles, 16 stalls
    instr(5'd6, 1'b1, 1'b1);
    id_rs1 = 5'd6;
    id_rs1_use = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      step();
    end
    check("sat_main_cnt", 64'(cnt), 64'd18);
    check("sat_narrow_cnt", 64'(cnt_s), 64'hF);
    check("sat_pending_stall", 64'(stall), 64'h1);

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check("arst_inflight", 64'(inflight), 64'h0);
    check("arst_cnt", 64'(cnt), 64'h0);
    check("arst_stall", 64'(stall), 64'h0);
    check("arst_fwd", 64'(rs1_fwd), 64'd0);
    check("arst_data", 64'(rs1_data), 64'h1111_1111);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
